// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared types, sizes and the slot-order helper for the FFT frame loader
// Optional build macro: FFT_LOADER_BITREV_EN (bit-reversed slot order)
// Revision: 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_N    = 4;
  localparam int SAMPLE_W = 16;
  localparam int LOG2N    = $clog2(FFT_N);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [FFT_N-1:0] frame_t;

  // Reverses the low 'width' bits of idx.
  function automatic int bitrev(input int idx, input int width);
    int r;
    r = 0;
    for (int b = 0; b < width; b++) begin
      if (idx[b]) r = r | (1 << (width - 1 - b));
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_bank.sv
// ============================================================================
// fft_frame_bank : one N-slot sample bank, written by write-order position,
// with zero-fill of all later positions when a frame closes early.
// Optional build macro: FFT_LOADER_BITREV_EN (position k lands in slot bitrev(k))
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int N            = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(N)-1:0]      wr_pos,
  input  logic [SAMPLE_WIDTH-1:0]   wr_data,
  input  logic                      close,
  output logic [N*SAMPLE_WIDTH-1:0] data
);

  localparam int ADDR_W = $clog2(N);

  // One register per write-order position; the position-to-lane mapping is a
  // fixed permutation, so each lane of 'data' has exactly one driver.
  for (genvar j = 0; j < N; j++) begin : g_slot
    localparam logic [ADDR_W-1:0] POS = ADDR_W'(j);
`ifdef FFT_LOADER_BITREV_EN
    localparam int SLOT = bitrev(j, ADDR_W);
`else
    localparam int SLOT = j;
`endif
    logic [SAMPLE_WIDTH-1:0] q;
    logic                    hit;
    logic                    pad;

    assign hit = (wr_pos == POS);
    assign pad = close && (int'(wr_pos) < j);

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (wr_en) begin
        if (hit)      q <= wr_data;
        else if (pad) q <= '0;
      end
    end

    assign data[SLOT*SAMPLE_WIDTH +: SAMPLE_WIDTH] = q;
  end

endmodule

`default_nettype wire

// File: rtl/fft_frame_loader.sv
// ============================================================================
// fft_frame_loader : packs a serial valid/ready sample stream into N-lane
// frames through a ping-pong pair of banks.
// Optional build macro: FFT_LOADER_BITREV_EN (bit-reversed lane order)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N            = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SAMPLE_WIDTH-1:0]   s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [N*SAMPLE_WIDTH-1:0] frame_data,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      frame_padded
);

  localparam int                ADDR_W   = $clog2(N);
  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(N - 1);

  logic [1:0]              full;
  logic [1:0]              padded;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [ADDR_W-1:0]       wr_cnt;
  logic                    accept;
  logic                    close;
  logic                    consume;
  logic [N*SAMPLE_WIDTH-1:0] bank_data [2];

  // Outputs are forced quiet while rst is high, before the registers settle.
  assign s_ready      = !rst && !full[wr_bank];
  assign accept       = s_valid && s_ready;
  assign close        = accept && (s_last || (wr_cnt == LAST_POS));
  assign frame_valid  = !rst && full[rd_bank];
  assign consume      = frame_valid && frame_ready;
  assign frame_padded = !rst && padded[rd_bank];
  assign frame_data   = rst ? '0 : bank_data[rd_bank];

  // A close always targets an empty bank and a consume a full one, so the two
  // never touch the same bit of full[] in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      padded  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      if (accept) begin
        wr_cnt <= close ? '0 : wr_cnt + 1'b1;
      end
      if (close) begin
        full[wr_bank]   <= 1'b1;
        padded[wr_bank] <= (wr_cnt != LAST_POS);
        wr_bank         <= ~wr_bank;
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK = 1'(b);
    logic bank_wr;

    assign bank_wr = accept && (wr_bank == BANK);

    fft_frame_bank #(
      .N            (N),
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_wr),
      .wr_pos  (wr_cnt),
      .wr_data (s_data),
      .close   (close),
      .data    (bank_data[b])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
// ============================================================================
// tb_fft_frame_loader : directed plus random stimulus against a queue-based
// frame model; a negedge monitor compares every presented frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fft_frame_loader;

`ifdef FFT_LOADER_BITREV_EN
  localparam int N = 8;
`else
  localparam int N = 4;
`endif
  localparam int SW = 16;
  localparam int LW = $clog2(N);
  localparam int FW = N * SW;

  typedef struct {
    logic [FW-1:0] data;
    logic          pad;
  } frame_s;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          frame_padded;

  frame_s        exp_q[$];
  logic [SW-1:0] partial[$];
  int            checks = 0;
  int            errors = 0;
  bit            m_acc;
  bit            m_cons;
  frame_s        nf;

  fft_frame_loader #(.N(N), .SAMPLE_WIDTH(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_padded (frame_padded)
  );

  always #5 clk = ~clk;

  // Lane of the k-th sample written into a frame.
  function automatic int slot(input int k);
`ifdef FFT_LOADER_BITREV_EN
    int r;
    int v;
    r = 0;
    v = k;
    for (int b = 0; b < LW; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor and reference model: outputs checked against the model, then the
  // model advances by what the coming posedge will do.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_ready", FW'(s_ready), '0);
      chk("rst_frame_valid", FW'(frame_valid), '0);
      chk("rst_frame_padded", FW'(frame_padded), '0);
      chk("rst_frame_data", frame_data, '0);
      exp_q.delete();
      partial.delete();
    end else begin
      chk("s_ready", FW'(s_ready), FW'(exp_q.size() < 2));
      chk("frame_valid", FW'(frame_valid), FW'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("frame_data", frame_data, exp_q[0].data);
        chk("frame_padded", FW'(frame_padded), FW'(exp_q[0].pad));
      end
      m_cons = (exp_q.size() > 0) && frame_ready;
      m_acc  = s_valid && (exp_q.size() < 2);
      if (m_cons) void'(exp_q.pop_front());
      if (m_acc) begin
        partial.push_back(s_data);
        if (s_last || partial.size() == N) begin
          nf.data = '0;
          for (int i = 0; i < partial.size(); i++)
            nf.data[slot(i)*SW +: SW] = partial[i];
          nf.pad = (partial.size() < N);
          exp_q.push_back(nf);
          partial.delete();
        end
      end
    end
  end

  task automatic send(input logic [SW-1:0] d, input logic last);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept data=%h", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous streaming with the consumer always ready
    frame_ready = 1'b1;
    for (int i = 1; i <= 2 * N; i++) send(SW'(i), 1'b0);
    idle(3);

    // Consumer stalled: both banks fill, then release
    frame_ready = 1'b0;
    fork
      for (int i = 1; i <= 3 * N; i++) send(SW'(i), 1'b0);
      begin
        repeat (3 * N + 10) @(posedge clk);
        #1 frame_ready = 1'b1;
      end
    join
    idle(5);

    // Short frame closed by s_last, then a full frame
    send(16'h000A, 1'b0);
    send(16'h000B, 1'b1);
    for (int i = 0; i < N; i++) send(SW'(16'h20 + i), 1'b0);
    idle(3);

    // s_last on the final slot; close and consume in the same cycle
    frame_ready = 1'b0;
    for (int i = 0; i < N - 1; i++) send(SW'(16'h30 + i), 1'b0);
    send(16'h003F, 1'b1);
    for (int i = 0; i < N - 1; i++) send(SW'(16'h40 + i), 1'b0);
    frame_ready = 1'b1;
    send(16'h004F, 1'b0);
    idle(4);

    // Reset with one frame held and one partially written
    frame_ready = 1'b0;
    for (int i = 0; i < N; i++) send(SW'(16'h50 + i), 1'b0);
    send(16'h0060, 1'b0);
    send(16'h0061, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < N; i++) send(SW'(16'h70 + i), 1'b0);
    idle(3);

    // Random traffic on both sides
    repeat (1500) begin
      @(posedge clk);
      #1;
      s_valid     = ($urandom % 4) != 0;
      s_data      = SW'($urandom);
      s_last      = ($urandom % 6) == 0;
      frame_ready = ($urandom % 3) != 0;
    end
    frame_ready = 1'b1;
    idle(10);
    chk("drain_empty", FW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
